// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 transmit scheduler.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        HOLD
    } sched_state_t;

    localparam logic [7:0]  BREAK_PREFIX = 8'hF0;
    localparam logic [7:0]  EXT_PREFIX   = 8'hE0;

    localparam int unsigned CLK_HZ  = 50_000_000;
    localparam int unsigned GAP_1MS = CLK_HZ / 1000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [N-1:0] w_mask;

    // Index of the k-th candidate after the pointer, wrapped into 0..N-1.
    function automatic int unsigned wrap_add(input logic [IDX_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        return (s >= N) ? (s - N) : s;
    endfunction

    // Scan candidates in priority order and keep the first active one.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_mask  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_mask = N'(1) << wrap_add(i_ptr, k);
            if (!o_valid && (|(i_req & w_mask))) begin
                o_valid = 1'b1;
                o_grant = w_mask;
                o_idx   = IDX_W'(wrap_add(i_ptr, k));
            end
        end
    end

endmodule

// File: rtl/ps2_tx_sched.sv
// Shares one PS/2 transmitter between N_REQ byte sources, keeping packets
// atomic, spacing frames by a gap and guarding every wait with a watchdog.
module ps2_tx_sched
    import ps2_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned GAP_CYCLES     = GAP_1MS,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_send,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   grant,
    output logic               active,
    output logic               timeout_err
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GP_W  = $clog2(GAP_CYCLES + 1);

    sched_state_t     r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner;
    logic             r_lock_end;
    logic [WD_W-1:0]  r_wd;
    logic [GP_W-1:0]  r_gap;
    logic [7:0]       r_tx_data;
    logic             r_tx_send;
    logic [N_REQ-1:0] r_grant;
    logic             r_active;
    logic             r_timeout_err;

    logic [N_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_sel_idx;
    logic [7:0]       w_sel_data;
    logic             w_sel_last;
    logic             w_accept;
    logic [IDX_W-1:0] w_next_ptr;
    logic             w_wd_exp;
    logic [WD_W-1:0]  w_wd_inc;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Ready goes to the arbiter pick in IDLE, the packet owner in HOLD, nobody otherwise.
    always_comb begin
        req_ready = '0;
        if (rst_n) begin
            if (r_state == IDLE && w_pick_valid) begin
                req_ready = w_pick_grant;
            end else if (r_state == HOLD) begin
                req_ready = r_grant;
            end
        end
    end

    // Byte/last mux for whichever requester is currently allowed to hand over.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                w_sel_data = req_data[8*i +: 8];
                w_sel_last = req_last[i];
            end
        end
    end

    assign w_sel_idx  = (r_state == HOLD) ? r_owner : w_pick_idx;
    assign w_accept   = |(req_valid & req_ready);
    assign w_next_ptr = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
    assign w_wd_exp   = (r_wd >= WD_W'(TIMEOUT_CYCLES - 1));
    assign w_wd_inc   = (r_wd == WD_W'(TIMEOUT_CYCLES)) ? r_wd : r_wd + WD_W'(1);

    // Scheduler FSM; the watchdog measures from the send pulse or from entry to a wait/HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_lock_end    <= 1'b0;
            r_wd          <= '0;
            r_gap         <= '0;
            r_tx_data     <= '0;
            r_tx_send     <= 1'b0;
            r_grant       <= '0;
            r_active      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_send     <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tx_data  <= w_sel_data;
                        r_lock_end <= w_sel_last;
                        r_grant    <= w_pick_grant;
                        r_owner    <= w_pick_idx;
                        r_tx_send  <= 1'b1;
                        r_active   <= 1'b1;
                        r_wd       <= '0;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    r_wd    <= w_wd_inc;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_wd    <= '0;
                        r_state <= WAIT_DONE;
                    end else if (w_wd_exp) begin
                        r_timeout_err <= 1'b1;
                        r_lock_end    <= 1'b1;
                        r_gap         <= GP_W'(1);
                        r_state       <= GAP;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_gap   <= GP_W'(1);
                        r_state <= GAP;
                    end else if (w_wd_exp) begin
                        r_timeout_err <= 1'b1;
                        r_lock_end    <= 1'b1;
                        r_gap         <= GP_W'(1);
                        r_state       <= GAP;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                GAP: begin
                    // The cycle that saw the frame end counts as the first gap clock.
                    if (r_gap >= GP_W'(GAP_CYCLES - 1)) begin
                        if (r_lock_end) begin
                            r_grant  <= '0;
                            r_active <= 1'b0;
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= IDLE;
                        end else begin
                            r_wd    <= '0;
                            r_state <= HOLD;
                        end
                    end else begin
                        r_gap <= r_gap + GP_W'(1);
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_tx_data  <= w_sel_data;
                        r_lock_end <= w_sel_last;
                        r_tx_send  <= 1'b1;
                        r_wd       <= '0;
                        r_state    <= SEND;
                    end else if (w_wd_exp) begin
                        r_timeout_err <= 1'b1;
                        r_grant       <= '0;
                        r_active      <= 1'b0;
                        r_rr_ptr      <= w_next_ptr;
                        r_state       <= IDLE;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_send     = r_tx_send;
    assign grant       = r_grant;
    assign active      = r_active;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ps2_tx_sched.sv
// Directed bench for ps2_tx_sched: table of single-byte transfers plus
// hand-written sequences for packets, fairness, watchdogs and reset.
module tb_ps2_tx_sched;
    import ps2_pkg::*;

    localparam int unsigned NR  = 2;
    localparam int unsigned GAP = 4;
    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant;
    logic        active;
    logic        timeout_err;

    ps2_tx_sched #(
        .N_REQ          (NR),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_busy     (tx_busy),
        .grant       (grant),
        .active      (active),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Transmitter model: busy rises 2 cycles after send and stays high 10 cycles.
    logic model_en = 1'b1;
    int   m_cnt = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            tx_busy <= 1'b0;
        end else if (tx_send && model_en) begin
            m_cnt <= 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 1) tx_busy <= 1'b1;
            if (m_cnt == 11) begin
                tx_busy <= 1'b0;
                m_cnt   <= 0;
            end
        end
    end

    // Requester sources: each queue entry is {last, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
            if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
            #1;
            if (q0.size() > 0) begin
                req_valid[0]  = 1'b1;
                req_data[7:0] = q0[0][7:0];
                req_last[0]   = q0[0][8];
            end else begin
                req_valid[0] = 1'b0;
                req_last[0]  = 1'b0;
            end
            if (q1.size() > 0) begin
                req_valid[1]   = 1'b1;
                req_data[15:8] = q1[0][7:0];
                req_last[1]    = q1[0][8];
            end else begin
                req_valid[1] = 1'b0;
                req_last[1]  = 1'b0;
            end
        end
    end

    // Observation log, sampled on the falling edge.
    logic [7:0] sent[$];
    logic [1:0] sent_grant[$];
    int         sent_cyc[$];
    int         n_err = 0;
    int         err_cyc = 0;
    logic [1:0] err_grant = '0;
    int         busy_fall_cyc = 0;
    int         busy_fall_at_err = 0;
    int         act_fall_cyc = 0;
    logic       prev_busy = 1'b0;
    logic       prev_active = 1'b0;
    always @(negedge clk) begin
        if (tx_send) begin
            sent.push_back(tx_data);
            sent_grant.push_back(grant);
            sent_cyc.push_back(cyc);
        end
        if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
        if (timeout_err) begin
            n_err++;
            err_cyc          = cyc;
            err_grant        = grant;
            busy_fall_at_err = busy_fall_cyc;
        end
        if (prev_active && !active) act_fall_cyc = cyc;
        prev_busy   = tx_busy;
        prev_active = active;
    end

    function automatic logic [7:0] sent_at(input int i);
        if (i < sent.size()) return sent[i];
        return 8'h00;
    endfunction

    function automatic logic [1:0] grant_at(input int i);
        if (i < sent_grant.size()) return sent_grant[i];
        return 2'b11;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < sent_cyc.size()) return sent_cyc[i];
        return -1000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        sent.delete();
        sent_grant.delete();
        sent_cyc.delete();
    endtask

    task automatic wait_sent(input int n, input int budget, input string name);
        int k = 0;
        while (sent.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check({name, "_wait_sent"}, 32'(sent.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (!(active == 1'b0 && q0.size() == 0 && q1.size() == 0 &&
                     req_valid == 2'b00 && tx_busy == 1'b0) && k < budget);
        check({name, "_wait_idle"}, 32'(k < budget), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         src;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] atom_exp[7];
    logic [7:0] fair_exp[6];

    initial begin
        int first_r1;
        int k;

        vecs[0] = '{0, 8'h1C,        8'h1C,        2'b01};
        vecs[1] = '{1, 8'h29,        8'h29,        2'b10};
        vecs[2] = '{0, BREAK_PREFIX, 8'hF0,        2'b01};
        vecs[3] = '{1, EXT_PREFIX,   8'hE0,        2'b10};
        atom_exp = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h29};
        fair_exp = '{8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'hAA, 8'hBB};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;

        // Single-byte transfers from a table
        for (int i = 0; i < 4; i++) begin
            clear_log();
            if (vecs[i].src == 0) q0.push_back({1'b1, vecs[i].data});
            else                  q1.push_back({1'b1, vecs[i].data});
            wait_sent(1, 200, $sformatf("vec%0d", i));
            wait_idle(200, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tx_data", i), 32'(sent_at(0)), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_grant_at_send", i), 32'(grant_at(0)), 32'(vecs[i].exp_grant));
            check($sformatf("vec%0d_send_count", i), 32'(sent.size()), 32'd1);
            check($sformatf("vec%0d_grant_after", i), 32'(grant), 32'd0);
            check($sformatf("vec%0d_active_fall_delay", i), 32'(act_fall_cyc - busy_fall_cyc), 32'(GAP));
        end

        // Packet atomicity: req1 waits until req0's six-byte packet ends
        apply_reset();
        clear_log();
        first_r1 = -1;
        q0.push_back({1'b0, 8'h12}); q0.push_back({1'b0, 8'h1C});
        q0.push_back({1'b0, 8'hF0}); q0.push_back({1'b0, 8'h1C});
        q0.push_back({1'b0, 8'hF0}); q0.push_back({1'b1, 8'h12});
        q1.push_back({1'b1, 8'h29});
        k = 0;
        while (sent.size() < 7 && k < 2000) begin
            @(negedge clk); #1;
            k++;
            if (req_ready[1] && first_r1 < 0) first_r1 = sent.size();
        end
        check("atom_wait_sent", 32'(sent.size() >= 7), 32'd1);
        for (int i = 0; i < 7; i++)
            check($sformatf("atom_byte%0d", i), 32'(sent_at(i)), 32'(atom_exp[i]));
        check("atom_r1_ready_after_packet", 32'(first_r1), 32'd6);
        for (int i = 1; i < 7; i++)
            check($sformatf("atom_spacing%0d", i),
                  32'(cyc_at(i) - cyc_at(i-1) >= int'(GAP) + 3), 32'd1);
        wait_idle(300, "atom");

        // Round-robin fairness after reset
        apply_reset();
        clear_log();
        repeat (3) begin
            q0.push_back({1'b1, 8'hAA});
            q1.push_back({1'b1, 8'hBB});
        end
        wait_sent(6, 2000, "fair");
        for (int i = 0; i < 6; i++)
            check($sformatf("fair_byte%0d", i), 32'(sent_at(i)), 32'(fair_exp[i]));
        wait_idle(300, "fair");

        // Transmitter never answers
        model_en = 1'b0;
        n_err = 0;
        clear_log();
        q0.push_back({1'b1, 8'h33});
        wait_sent(1, 200, "txto");
        wait_idle(300, "txto");
        check("txto_err_count", 32'(n_err), 32'd1);
        check("txto_err_delay", 32'(err_cyc - cyc_at(0)), 32'(TMO));
        check("txto_grant_after", 32'(grant), 32'd0);
        model_en = 1'b1;
        clear_log();
        q0.push_back({1'b1, 8'h44});
        wait_sent(1, 200, "txto_next");
        wait_idle(300, "txto_next");
        check("txto_next_data", 32'(sent_at(0)), 32'h44);
        check("txto_next_no_err", 32'(n_err), 32'd1);

        // Owner goes silent in HOLD
        apply_reset();
        n_err = 0;
        clear_log();
        first_r1 = -1;
        q0.push_back({1'b0, 8'h12});
        q1.push_back({1'b1, 8'h5A});
        k = 0;
        while (sent.size() < 2 && k < 2000) begin
            @(negedge clk); #1;
            k++;
            if (req_ready[1] && first_r1 < 0) first_r1 = n_err;
        end
        check("hold_wait_sent", 32'(sent.size() >= 2), 32'd1);
        wait_idle(300, "hold");
        check("hold_err_count", 32'(n_err), 32'd1);
        check("hold_err_delay", 32'(err_cyc - busy_fall_at_err), 32'(GAP + TMO));
        check("hold_err_grant", 32'(err_grant), 32'd0);
        check("hold_r1_ready_after_err", 32'(first_r1), 32'd1);
        check("hold_byte0", 32'(sent_at(0)), 32'h12);
        check("hold_byte1", 32'(sent_at(1)), 32'h5A);
        check("hold_byte1_grant", 32'(grant_at(1)), 32'b10);

        // Asynchronous reset while the frame is in flight
        clear_log();
        q0.push_back({1'b1, 8'h77});
        wait_sent(1, 200, "arst");
        k = 0;
        while (tx_busy == 1'b0 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check("arst_busy_seen", 32'(tx_busy), 32'd1);
        @(negedge clk); #1;
        q1.push_back({1'b1, 8'h66});
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("arst_pre_active", 32'(active), 32'd1);
        check("arst_pre_grant", 32'(grant), 32'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx_send", 32'(tx_send), 32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_active", 32'(active), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'd0);
        repeat (2) @(negedge clk);
        q0.push_back({1'b1, 8'h55});
        @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        wait_sent(1, 200, "arst_after");
        check("arst_first_data", 32'(sent_at(0)), 32'h55);
        check("arst_first_grant", 32'(grant_at(0)), 32'b01);
        wait_idle(400, "arst_after");
        check("arst_second_data", 32'(sent_at(1)), 32'h66);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Overall runaway guard
    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "global timeout");
    end

endmodule
